imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 62 ++++++
 rtl/imem_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Bus bundle between the board-side controller (switches, debounced buttons,
// PC) and the instruction-memory loader.
//
//   inst_in     : instruction word from the board switches
//   load_pulse  : one-cycle pulse, store inst_in at the write pointer
//   clear_pulse : one-cycle pulse, empty the program
//   run_pulse   : one-cycle pulse, toggle LOAD <-> RUN
//   read_addr   : instruction address from the PC
//   read_data   : instruction at read_addr (combinational)
//   wr_ptr      : next write address
//   count       : number of loaded words
//   full        : count has reached DEPTH
//   running     : loader is in RUN
//   load_err    : sticky misuse flag
//
// The master modport is the controller side; the slave modport is the loader.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] inst_in;
  logic             load_pulse;
  logic             clear_pulse;
  logic             run_pulse;
  logic [4:0]       read_addr;
  logic [WIDTH-1:0] read_data;
  logic [4:0]       wr_ptr;
  logic [5:0]       count;
  logic             full;
  logic             running;
  logic             load_err;

  modport master (
    output inst_in,
    output load_pulse,
    output clear_pulse,
    output run_pulse,
    output read_addr,
    input  read_data,
    input  wr_ptr,
    input  count,
    input  full,
    input  running,
    input  load_err
  );

  modport slave (
    input  inst_in,
    input  load_pulse,
    input  clear_pulse,
    input  run_pulse,
    input  read_addr,
    output read_data,
    output wr_ptr,
    output count,
    output full,
    output running,
    output load_err
  );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Small instruction memory that a user fills word by word from board switches
// (LOAD state) and that a CPU then fetches from (RUN state).
//
// Ports:
//   clk   : single clock, all state updates on its rising edge
//   reset : synchronous, active-low reset (state LOAD, memory and counters 0)
//   bus   : imem_loader_if.slave, see the interface file for each signal
//
// Parameters:
//   DEPTH     : number of instruction words (power of two, at most 32)
//   WIDTH     : instruction word width
//   HALT_WORD : word returned for addresses outside the program
//
// Optional feature:
//   IMEM_LOADER_GUARD_EN : when defined, reads at addresses not yet loaded
//                          (read_addr >= count, unless full) return HALT_WORD
//                          so a runaway PC halts instead of executing zeros.
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int               DEPTH     = 32,
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] HALT_WORD = 16'hE000
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  // Address bits actually used to index the storage array.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    LOAD_S = 1'b0,
    RUN_S  = 1'b1
  } state_t;

  state_t           state_q,    state_d;
  logic [4:0]       wr_ptr_q,   wr_ptr_d;
  logic [5:0]       count_q,    count_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             full_w;
  logic [WIDTH-1:0] rd_word;

  assign full_w = (count_q == 6'(DEPTH));

  // -------------------------------------------------------------------------
  // Next-state logic. Within LOAD the clear/load is resolved first, and the
  // run decision then looks at the resulting count, so a load coinciding with
  // run_pulse on an empty program still enters RUN, and a clear coinciding
  // with run_pulse refuses and flags the error.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    load_err_d = load_err_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    case (state_q)
      LOAD_S: begin
        if (bus.clear_pulse) begin
          // Clear beats a coincident load; the load is simply dropped.
          wr_ptr_d   = '0;
          count_d    = '0;
          load_err_d = 1'b0;
          for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
          end
        end else if (bus.load_pulse) begin
          if (full_w) begin
            load_err_d = 1'b1;
          end else begin
            mem_d[wr_ptr_q[AW-1:0]] = bus.inst_in;
            // After the DEPTH-th write the pointer wraps to 0; full tells
            // that case apart from an empty program.
            wr_ptr_d = (wr_ptr_q == 5'(DEPTH - 1)) ? 5'd0 : wr_ptr_q + 5'd1;
            count_d  = count_q + 6'd1;
          end
        end

        if (bus.run_pulse) begin
          if (count_d != 6'd0) begin
            state_d = RUN_S;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end

      RUN_S: begin
        // Program is frozen while running; any edit attempt is flagged.
        if (bus.load_pulse || bus.clear_pulse) begin
          load_err_d = 1'b1;
        end
        if (bus.run_pulse) begin
          state_d = LOAD_S;
        end
      end

      default: begin
        state_d = LOAD_S;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. Memory is reset along with control so that a reset
  // always leaves an empty, all-zero program.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= LOAD_S;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      load_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      load_err_q <= load_err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read port: purely combinational from the registered array, so a word
  // being written this cycle still reads back its old value until the edge.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    if (32'(bus.read_addr) >= 32'(DEPTH)) begin
      rd_word = HALT_WORD;
    end else begin
`ifdef IMEM_LOADER_GUARD_EN
      if (({1'b0, bus.read_addr} >= count_q) && !full_w) begin
        rd_word = HALT_WORD;
      end else begin
        rd_word = mem_q[bus.read_addr[AW-1:0]];
      end
`else
      rd_word = mem_q[bus.read_addr[AW-1:0]];
`endif
    end
  end

  assign bus.read_data = rd_word;
  assign bus.wr_ptr    = wr_ptr_q;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.running   = (state_q == RUN_S);
  assign bus.load_err  = load_err_q;

endmodule
